// File: rtl/result_slot_arbiter.sv
// Round-robin arbiter that grants NUM_REQ producers one fixed-stride slot at a time in a ring of result slots.
// Optional build define RESULT_ARB_BEAT_LIMIT_EN drops beats that would run past the end of a slot.
module result_slot_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned NUM_SLOTS   = 5,
  parameter int unsigned SLOT_STRIDE = 1550,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  input  logic               wr_valid,
  input  logic               wr_last,
  input  logic               slot_release,
  output logic [ADDR_W-1:0]  addr_out,
  output logic               write_enable,
  output logic               commit,
  output logic [2:0]         commit_slot,
  output logic [ADDR_W-1:0]  rd_addr,
  output logic [2:0]         occupancy,
  output logic               full,
  output logic               empty,
  output logic               trunc_err
);

  localparam int unsigned REQ_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned SLOT_W = 3;
  localparam int unsigned OFF_W  = 11;

  typedef enum logic [1:0] {IDLE, GRANT, WRITE, COMMIT} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [REQ_W-1:0]   win_q, win_d;
  logic [REQ_W-1:0]   last_winner_q, last_winner_d;
  logic [OFF_W-1:0]   offset_q, offset_d;
  logic [SLOT_W-1:0]  wr_slot_q, wr_slot_d;
  logic [SLOT_W-1:0]  rd_slot_q, rd_slot_d;
  logic [SLOT_W-1:0]  occ_q, occ_d;
  logic [SLOT_W-1:0]  commit_slot_q, commit_slot_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic               we_q, we_d;
  logic               commit_q, commit_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               trunc_q, trunc_d;

  logic               rr_found;
  logic [REQ_W-1:0]   rr_idx;
  logic               commit_inc;
  logic               release_ok;
  logic [ADDR_W-1:0]  wr_base;

  // First requester at or after last_winner+1, wrapping; returns {found, index}.
  function automatic logic [REQ_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [REQ_W-1:0]   last);
    logic             found;
    logic [REQ_W-1:0] idx;
    int unsigned      cand;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(last) + i) % NUM_REQ;
      if (!found && r[REQ_W'(cand)]) begin
        found = 1'b1;
        idx   = REQ_W'(cand);
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    {rr_found, rr_idx} = rr_pick(req, last_winner_q);
  end

  assign wr_base = ADDR_W'(wr_slot_q) * ADDR_W'(SLOT_STRIDE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      gnt_q         <= '0;
      win_q         <= '0;
      last_winner_q <= REQ_W'(NUM_REQ - 1);
      offset_q      <= '0;
      wr_slot_q     <= '0;
      rd_slot_q     <= '0;
      occ_q         <= '0;
      commit_slot_q <= '0;
      addr_q        <= '0;
      rd_addr_q     <= '0;
      we_q          <= 1'b0;
      commit_q      <= 1'b0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      trunc_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      win_q         <= win_d;
      last_winner_q <= last_winner_d;
      offset_q      <= offset_d;
      wr_slot_q     <= wr_slot_d;
      rd_slot_q     <= rd_slot_d;
      occ_q         <= occ_d;
      commit_slot_q <= commit_slot_d;
      addr_q        <= addr_d;
      rd_addr_q     <= rd_addr_d;
      we_q          <= we_d;
      commit_q      <= commit_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      trunc_q       <= trunc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    win_d         = win_q;
    last_winner_d = last_winner_q;
    offset_d      = offset_q;
    wr_slot_d     = wr_slot_q;
    commit_slot_d = commit_slot_q;
    addr_d        = addr_q;
    we_d          = 1'b0;
    commit_d      = 1'b0;
    trunc_d       = 1'b0;
    commit_inc    = 1'b0;

    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (rr_found && !full_q) begin
          win_d   = rr_idx;
          gnt_d   = NUM_REQ'(1) << rr_idx;
          state_d = GRANT;
        end
      end
      GRANT: begin
        offset_d = '0;
        state_d  = WRITE;
      end
      WRITE: begin
        // req is deliberately ignored here; only wr_last closes the packet.
        if (wr_valid) begin
`ifdef RESULT_ARB_BEAT_LIMIT_EN
          if (offset_q >= OFF_W'(SLOT_STRIDE)) begin
            trunc_d = 1'b1;
          end else begin
            we_d     = 1'b1;
            addr_d   = wr_base + ADDR_W'(offset_q);
            offset_d = offset_q + OFF_W'(1);
          end
`else
          we_d     = 1'b1;
          addr_d   = wr_base + ADDR_W'(offset_q);
          offset_d = offset_q + OFF_W'(1);
`endif
          if (wr_last) begin
            state_d = COMMIT;
          end
        end
      end
      COMMIT: begin
        commit_d      = 1'b1;
        commit_slot_d = wr_slot_q;
        commit_inc    = 1'b1;
        last_winner_d = win_q;
        gnt_d         = '0;
        wr_slot_d     = (wr_slot_q == SLOT_W'(NUM_SLOTS - 1)) ? '0 : wr_slot_q + SLOT_W'(1);
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Ring bookkeeping: commit and an accepted release may land in the same cycle.
  always_comb begin
    release_ok = slot_release && (occ_q != '0);
    rd_slot_d  = rd_slot_q;
    if (release_ok) begin
      rd_slot_d = (rd_slot_q == SLOT_W'(NUM_SLOTS - 1)) ? '0 : rd_slot_q + SLOT_W'(1);
    end
    occ_d     = occ_q + SLOT_W'(commit_inc) - SLOT_W'(release_ok);
    full_d    = (occ_d == SLOT_W'(NUM_SLOTS));
    empty_d   = (occ_d == '0);
    rd_addr_d = ADDR_W'(rd_slot_d) * ADDR_W'(SLOT_STRIDE);
  end

  assign gnt          = gnt_q;
  assign addr_out     = addr_q;
  assign write_enable = we_q;
  assign commit       = commit_q;
  assign commit_slot  = commit_slot_q;
  assign rd_addr      = rd_addr_q;
  assign occupancy    = occ_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign trunc_err    = trunc_q;

endmodule

// File: doc/result_slot_arbiter.md
RESULT_SLOT_ARBITER -- requirements
Module: result_slot_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): NUM_REQ, 4, number of result producers; NUM_SLOTS, 5, ring slots in result buffer; SLOT_STRIDE, 1550, words per slot; ADDR_W, 32, address width.
REQ-002 SHALL have ports (name, direction, width, meaning) in this order:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-producer request to write one result packet.
- gnt  out  NUM_REQ  one-hot grant, registered.
- wr_valid  in  1  data beat from the granted producer (externally muxed by gnt).
- wr_last  in  1  final beat of the packet; qualified by wr_valid.
- slot_release  in  1  host has consumed the oldest committed slot.
- addr_out  out  ADDR_W  buffer write address, registered.
- write_enable  out  1  buffer write strobe, registered.
- commit  out  1  one-cycle pulse: a slot was committed.
- commit_slot  out  3  index of the slot committed with commit.
- rd_addr  out  ADDR_W  base address of the oldest committed slot.
- occupancy  out  3  committed, unreleased slots (0..NUM_SLOTS).
- full  out  1  occupancy == NUM_SLOTS.
- empty  out  1  occupancy == 0.
- trunc_err  out  1  one-cycle pulse: beat dropped by the length guard (REQ-019).

Function
REQ-003 SHALL implement FSM states IDLE, GRANT, WRITE, COMMIT.
REQ-004 IDLE: if any req bit set and full==0, SHALL latch the round-robin winner, set gnt to its one-hot and go to GRANT; otherwise SHALL stay in IDLE with gnt==0.
REQ-005 Round-robin: search SHALL start at (last_winner+1) mod NUM_REQ; last_winner SHALL update only in COMMIT.
REQ-006 GRANT: one cycle; SHALL clear the beat offset to 0 and go to WRITE; write_enable SHALL stay 0.
REQ-007 WRITE: on each cycle with wr_valid=1, SHALL drive write_enable=1 and addr_out=wr_slot*SLOT_STRIDE+offset on the next cycle (latency 1), then increment offset.
REQ-008 WRITE: cycles with wr_valid=0 SHALL drive write_enable=0 and hold addr_out.
REQ-009 WRITE: wr_valid=1 with wr_last=1 SHALL write that beat and go to COMMIT.
REQ-010 Deassertion of req by the granted producer during GRANT/WRITE SHALL be ignored; only wr_last ends the packet.
REQ-011 COMMIT: one cycle; SHALL pulse commit with commit_slot=wr_slot, advance wr_slot modulo NUM_SLOTS (4 wraps to 0), increment occupancy, clear gnt and return to IDLE.
REQ-012 slot_release with occupancy>0 SHALL advance rd_slot modulo NUM_SLOTS and decrement occupancy; with occupancy==0 it SHALL be ignored.
REQ-013 commit and an accepted slot_release in the same cycle SHALL leave occupancy unchanged while both pointers advance.
REQ-014 rd_addr SHALL equal rd_slot*SLOT_STRIDE (0, 1550, 3100, 4650, 6200), zero-extended to ADDR_W.
REQ-015 full and empty SHALL be decoded from registered occupancy; a full ring SHALL block new grants but never abort a packet in progress.
REQ-016 The offset counter SHALL be 11 bits; address arithmetic SHALL be unsigned, zero-extended to ADDR_W.

Reset
REQ-017 rst=1 at a clock edge SHALL force state=IDLE, gnt=0, addr_out=0, write_enable=0, commit=0, commit_slot=0, trunc_err=0, wr_slot=0, rd_slot=0, occupancy=0, empty=1, full=0, and last_winner=NUM_REQ-1 (requester 0 wins first).
REQ-018 Reset asserted mid-packet SHALL abandon the packet without a commit pulse; all inputs SHALL be ignored while rst=1.

Configuration
REQ-019 With RESULT_ARB_BEAT_LIMIT_EN defined: beats with offset>=SLOT_STRIDE SHALL assert no write_enable and SHALL pulse trunc_err; offset SHALL saturate; wr_last SHALL still commit.
REQ-020 Without RESULT_ARB_BEAT_LIMIT_EN: every beat SHALL write (addresses may run into the next slot); trunc_err SHALL be tied to 0.

Verification
REQ-021 Reset, then req=0001 with a 3-beat packet -> gnt=0001, addresses 0,1,2 with write_enable, commit with commit_slot=0, occupancy=1.
REQ-022 req=1111 held over 4 packets -> grant order 0,1,2,3; slot bases 0, 1550, 3100, 4650.
REQ-023 Commit 5 packets with no release -> full=1, no grant for pending req; one slot_release -> grant issues, next packet writes at base 0 (wrap).
REQ-024 commit and slot_release in the same cycle at occupancy=2 -> occupancy stays 2, rd_addr advances by 1550.
REQ-025 rst pulsed mid-WRITE after 2 beats -> no commit, occupancy=0, next grant goes to requester 0 and writes at address 0.
REQ-026 With macro: 1552-beat packet -> write_enable on 1550 beats, trunc_err pulses twice, one commit; without macro: 1552 writes, trunc_err=0.
